alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, pipelined integer ALU; next generation of the single-cycle backend ALU.
- Sits between the integer issue queue and the writeback network.
- Adds the following over a single-cycle ALU: configurable XLEN (32/64) and pipeline depth, RV64 word-mode (W) ops, valid/ready back-pressure, and ROB-index-based flush of in-flight younger ops.
- Operand selection (imm vs rs2, PC-relative values) is done upstream; this block receives final src1/src2.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- STAGES, 2, number of pipeline register stages, 1..4; issue-to-output latency in cycles.
- ROB_W, 6, ROB index width excluding the wrap (direction) bit.
- RD_W, 7, physical destination register index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  op offered
- in_ready  out  1  op accepted when in_valid & in_ready
- in_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS(src2); 11-15 reserved
- in_word  in  1  W-mode; ignored when XLEN=32
- in_src1  in  XLEN  operand 1
- in_src2  in  XLEN  operand 2
- in_rob  in  ROB_W+1  {wrap bit, ROB index}
- in_rd  in  RD_W  destination register
- flush_valid  in  1  redirect
- flush_rob  in  ROB_W+1  redirecting instruction; strictly younger ops are killed
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_res  out  XLEN  result
- out_rob  out  ROB_W+1  tag of result
- out_rd  out  RD_W  destination
- occupancy  out  $clog2(STAGES+1)  number of valid stages

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits = 0, so out_valid=0 and occupancy=0. in_ready=1 once rst is released. Data/tag registers are don't-care, but out_res/out_rob/out_rd read 0 under reset.
- Compute:
  - Result is computed combinationally from in_* and captured into stage 1. Stages 2..STAGES only carry it.
  - Output is driven from stage STAGES.
- Arithmetic:
  - ADD/SUB are mod 2^XLEN.
  - Shift amount = src2[log2(XLEN)-1:0]. SRA fills with src1 MSB.
  - SLT/SLTU return 0/1 zero-extended; signed compare for SLT, unsigned for SLTU.
  - Reserved ops return 0.
- W-mode (XLEN=64, in_word=1):
  - Operate on src1[31:0]/src2[31:0] with shift amount src2[4:0].
  - SRA fills from src1[31]; SRL zero-fills from bit 31.
  - Sign-extend bit 31 of the 32-bit result to 64 bits. Applies to ADD, SUB, SLL, SRL, SRA only; other ops ignore in_word.
- Handshake:
  - Stage k advances if it is valid and (stage k+1 is empty or stage k+1 advances). The last stage advances when out_ready=1.
  - in_ready = ~stage1.valid | stage1 advances (fully combinational ready chain, no bubbles).
  - out_* stay stable while out_valid & ~out_ready, unless a flush kills that stage.
- Latency: STAGES cycles with no back-pressure. Throughput is 1 op/cycle.
- Age compare: A is younger than B when
  - wrap bits are equal and idxA > idxB, or
  - wrap bits differ and idxA < idxB.
- Flush:
  - In the flush_valid cycle, every stage whose rob is strictly younger than flush_rob is invalidated at the next edge.
  - An op handshaking in that same cycle is also checked and dropped if younger; in_ready is not altered by flush.
  - out_valid is masked combinationally in the flush cycle for a killed last stage, so no killed result is written back.
  - Ops equal to or older than flush_rob continue unaffected.
  - Surviving ops keep their order. A kill creates a bubble, which later stages close normally.
- occupancy equals the count of valid stages after the edge, and updates every cycle.
- Reset mid-operation: all in-flight ops are discarded immediately; no output pulse occurs.
- Simultaneous events: flush, input accept and output accept in one cycle must all resolve consistently with the rules above.

Test Plan:
- XLEN=64, STAGES=2:
  - ADD src1=0xFFFF_FFFF_FFFF_FFFF, src2=1 -> out_res=0 exactly 2 cycles after accept, out_rob/out_rd match the input.
  - ADD with word=1, src1=0x7FFF_FFFF, src2=1 -> 0xFFFF_FFFF_8000_0000.
  - SRA with word=1, src1=0x0000_0000_8000_0000, src2=4 -> 0xFFFF_FFFF_F800_0000.
  - SRA with word=0, same operands -> 0x0000_0000_0800_0000.
- SLT src1=-1, src2=1 -> 1; SLTU with the same operands -> 0; reserved op 13 -> 0.
- Back-to-back issue of 6 ops with out_ready held 0 after the first 2 are accepted:
  - in_ready drops once both stages are full; occupancy reaches 2; out_* hold stable.
  - After out_ready=1, all 6 results emerge in order with no loss or duplication.
- Flush:
  - Stages hold rob {0,5} and {0,7}, input rob {0,8} is handshaking, flush_rob={0,6} -> {0,7} and {0,8} are killed, {0,5} completes.
  - Wrap case: flush_rob={1,1} with in-flight {0,62} and {1,2} -> only {1,2} is killed.
- Assert rst low while 2 ops are in flight and out_valid=1 -> out_valid=0 and occupancy=0 in the same cycle; after release, in_ready=1 and no stale result appears.
- STAGES=1 and STAGES=4 with XLEN=32 -> latency of 1 and 4 cycles respectively; in_word is ignored (ADD 0x7FFFFFFF+1 -> 0x80000000).

Source files
------------

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module      : alu_pipe_if
// Description : Issue, flush and writeback signal bundle for alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int ROB_W  = 6,
  parameter int RD_W   = 7
);
  logic                         in_valid;
  logic                         in_ready;
  logic [3:0]                   in_op;
  logic                         in_word;
  logic [XLEN-1:0]              in_src1;
  logic [XLEN-1:0]              in_src2;
  logic [ROB_W:0]               in_rob;
  logic [RD_W-1:0]              in_rd;
  logic                         flush_valid;
  logic [ROB_W:0]               flush_rob;
  logic                         out_valid;
  logic                         out_ready;
  logic [XLEN-1:0]              out_res;
  logic [ROB_W:0]               out_rob;
  logic [RD_W-1:0]              out_rd;
  logic [$clog2(STAGES+1)-1:0]  occupancy;

  modport slave (
    input  in_valid, in_op, in_word, in_src1, in_src2, in_rob, in_rd,
    input  flush_valid, flush_rob, out_ready,
    output in_ready, out_valid, out_res, out_rob, out_rd, occupancy
  );

  modport master (
    output in_valid, in_op, in_word, in_src1, in_src2, in_rob, in_rd,
    output flush_valid, flush_rob, out_ready,
    input  in_ready, out_valid, out_res, out_rob, out_rd, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Pipelined integer ALU with back-pressure and ROB-age flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int ROB_W  = 6,
  parameter int RD_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  alu_pipe_if.slave   bus
);

  localparam int c_SH_W  = $clog2(XLEN);
  localparam int c_TAG_W = ROB_W + 1;
  localparam int c_OCC_W = $clog2(STAGES + 1);
  localparam int c_LAST  = STAGES - 1;

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_SLL  = 4'd2;
  localparam logic [3:0] c_OP_SLT  = 4'd3;
  localparam logic [3:0] c_OP_SLTU = 4'd4;
  localparam logic [3:0] c_OP_XOR  = 4'd5;
  localparam logic [3:0] c_OP_SRL  = 4'd6;
  localparam logic [3:0] c_OP_SRA  = 4'd7;
  localparam logic [3:0] c_OP_OR   = 4'd8;
  localparam logic [3:0] c_OP_AND  = 4'd9;
  localparam logic [3:0] c_OP_PASS = 4'd10;

  // a younger than b, with the wrap bit disambiguating index roll-over
  function automatic logic younger(input logic [c_TAG_W-1:0] a,
                                   input logic [c_TAG_W-1:0] b);
    if (a[ROB_W] == b[ROB_W]) return a[ROB_W-1:0] > b[ROB_W-1:0];
    else                      return a[ROB_W-1:0] < b[ROB_W-1:0];
  endfunction

  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [c_SH_W-1:0] w_sh;
  logic [XLEN-1:0]   w_full_res;
  logic [XLEN-1:0]   w_word_res;
  logic              w_use_word;
  logic [XLEN-1:0]   w_res;

  assign w_a  = bus.in_src1;
  assign w_b  = bus.in_src2;
  assign w_sh = bus.in_src2[c_SH_W-1:0];

  always_comb begin
    w_full_res = '0;
    case (bus.in_op)
      c_OP_ADD:  w_full_res = w_a + w_b;
      c_OP_SUB:  w_full_res = w_a - w_b;
      c_OP_SLL:  w_full_res = w_a << w_sh;
      c_OP_SLT:  w_full_res = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      c_OP_SLTU: w_full_res = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      c_OP_XOR:  w_full_res = w_a ^ w_b;
      c_OP_SRL:  w_full_res = w_a >> w_sh;
      c_OP_SRA:  w_full_res = $signed(w_a) >>> w_sh;
      c_OP_OR:   w_full_res = w_a | w_b;
      c_OP_AND:  w_full_res = w_a & w_b;
      c_OP_PASS: w_full_res = w_b;
      default:   w_full_res = '0;
    endcase
  end

  if (XLEN == 64) begin : g_word
    logic [31:0] w_a32;
    logic [31:0] w_b32;
    logic [4:0]  w_sh32;
    logic [31:0] w_r32;
    logic        w_wop;

    assign w_a32  = w_a[31:0];
    assign w_b32  = w_b[31:0];
    assign w_sh32 = w_b[4:0];

    always_comb begin
      w_r32 = '0;
      w_wop = 1'b1;
      case (bus.in_op)
        c_OP_ADD: w_r32 = w_a32 + w_b32;
        c_OP_SUB: w_r32 = w_a32 - w_b32;
        c_OP_SLL: w_r32 = w_a32 << w_sh32;
        c_OP_SRL: w_r32 = w_a32 >> w_sh32;
        c_OP_SRA: w_r32 = $signed(w_a32) >>> w_sh32;
        default:  w_wop = 1'b0;
      endcase
    end

    assign w_word_res = {{(XLEN-32){w_r32[31]}}, w_r32};
    assign w_use_word = bus.in_word & w_wop;
  end else begin : g_noword
    assign w_word_res = '0;
    assign w_use_word = 1'b0;
  end

  assign w_res = w_use_word ? w_word_res : w_full_res;

  logic [STAGES-1:0] w_valid_vec;
  logic [STAGES-1:0] w_adv;
  logic              w_accept;
  logic [c_OCC_W-1:0] w_occ;

  // Ready chain walks from the output back toward stage 1
  always_comb begin
    w_adv = '0;
    w_adv[c_LAST] = w_valid_vec[c_LAST] & bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = w_valid_vec[k] & (~w_valid_vec[k+1] | w_adv[k+1]);
    end
  end

  assign bus.in_ready = ~w_valid_vec[0] | w_adv[0];
  assign w_accept     = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic               r_valid;
    logic [XLEN-1:0]    r_res;
    logic [c_TAG_W-1:0] r_rob;
    logic [RD_W-1:0]    r_rd;
    logic [XLEN-1:0]    w_src_res;
    logic [c_TAG_W-1:0] w_src_rob;
    logic [RD_W-1:0]    w_src_rd;
    logic               w_load;
    logic               w_kill_in;
    logic               w_kill_hold;

    if (k == 0) begin : g_first
      assign w_src_res = w_res;
      assign w_src_rob = bus.in_rob;
      assign w_src_rd  = bus.in_rd;
      assign w_load    = w_accept;
    end else begin : g_next
      assign w_src_res = g_stage[k-1].r_res;
      assign w_src_rob = g_stage[k-1].r_rob;
      assign w_src_rd  = g_stage[k-1].r_rd;
      assign w_load    = w_adv[k-1];
    end

    assign w_kill_in   = bus.flush_valid & younger(w_src_rob, bus.flush_rob);
    assign w_kill_hold = bus.flush_valid & younger(r_rob, bus.flush_rob);
    assign w_valid_vec[k] = r_valid;

    // Payload only moves on load so a stalled output stays stable
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid <= 1'b0;
        r_res   <= '0;
        r_rob   <= '0;
        r_rd    <= '0;
      end else if (w_load) begin
        r_valid <= ~w_kill_in;
        r_res   <= w_src_res;
        r_rob   <= w_src_rob;
        r_rd    <= w_src_rd;
      end else if (w_adv[k]) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid & ~w_kill_hold;
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ = w_occ + c_OCC_W'(w_valid_vec[k]);
    end
  end

  assign bus.occupancy = w_occ;
  assign bus.out_valid = g_stage[c_LAST].r_valid & ~g_stage[c_LAST].w_kill_hold;
  assign bus.out_res   = g_stage[c_LAST].r_res;
  assign bus.out_rob   = g_stage[c_LAST].r_rob;
  assign bus.out_rd    = g_stage[c_LAST].r_rd;

endmodule

`default_nettype wire
